// File: rtl/sbm_pkg.sv
// rtl/sbm_pkg.sv - shared types and helpers for the radix-4 Booth sequential multiplier
package sbm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } sbm_state_e;

    // -0 (triple 111) is folded into ZERO; it contributes nothing to the sum
    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_e;

    // Radix-4 digits needed to cover a WIDTH+2 bit extended operand
    function automatic int iter_count(input int width);
        return (width / 2) + 1;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// rtl/booth_r4_encoder.sv - modified Booth radix-4 digit recoder
module booth_r4_encoder
    import sbm_pkg::*;
(
    input  logic [2:0]   triple_i,
    output booth_digit_e digit_o
);

    // Map {q[2i+1], q[2i], q[2i-1]} to the signed digit it represents
    always_comb begin
        digit_o = ZERO;
        case (triple_i)
            3'b001, 3'b010: digit_o = POS1;
            3'b011:         digit_o = POS2;
            3'b100:         digit_o = NEG2;
            3'b101, 3'b110: digit_o = NEG1;
            default:        digit_o = ZERO;
        endcase
    end

endmodule

// File: rtl/seq_booth_multiplier.sv
// rtl/seq_booth_multiplier.sv - multi-cycle radix-4 Booth multiplier with signed/unsigned mode
module seq_booth_multiplier
    import sbm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset_in,
    input  logic               start_in,
    input  logic               signed_in,
    input  logic [WIDTH-1:0]   multiplicand_in,
    input  logic [WIDTH-1:0]   multiplier_in,
    output logic               busy_out,
    output logic               done_out,
    output logic [2*WIDTH-1:0] product_out,
    output logic               overflow_out
);

    localparam int ITER = iter_count(WIDTH);
    // Extended operand width: room for sign/zero extension plus the last Booth triple
    localparam int XW   = WIDTH + 2;
    // Accumulator: extended operand plus 2M growth plus one guard bit
    localparam int AW   = WIDTH + 4;
    localparam int CW   = $clog2(ITER + 1);

    generate
        if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("seq_booth_multiplier: WIDTH must be even and >= 4");
        end
    endgenerate

    sbm_state_e         state_q;
    logic [CW-1:0]      count_q;
    logic               mode_q;
    logic [XW-1:0]      m_q;
    logic [XW-1:0]      q_q;
    logic               qm1_q;
    logic [AW-1:0]      acc_q;
    logic [2*WIDTH-1:0] product_q;
    logic               overflow_q;
    logic               busy_q;
    logic               done_q;

    logic [XW-1:0]      m_ext_in;
    logic [XW-1:0]      q_ext_in;
    logic               accept;
    booth_digit_e       digit;
    logic [AW-1:0]      m_wide;
    logic [AW-1:0]      pp;
    logic [AW-1:0]      sum;
    logic [AW-1:0]      acc_d;
    logic [XW-1:0]      q_d;
    logic               qm1_d;
    logic [2*WIDTH-1:0] product_d;
    logic               overflow_d;

    booth_r4_encoder u_encoder (
        .triple_i ({q_q[1:0], qm1_q}),
        .digit_o  (digit)
    );

    // Operand extension and accept decision for a new request
    always_comb begin
        m_ext_in = signed_in ? {{2{multiplicand_in[WIDTH-1]}}, multiplicand_in}
                             : {2'b00, multiplicand_in};
        q_ext_in = signed_in ? {{2{multiplier_in[WIDTH-1]}}, multiplier_in}
                             : {2'b00, multiplier_in};
        accept   = start_in && (state_q != CALC);
    end

    // One Booth step: add d*M at the top, then shift {acc, q, q[-1]} right by two
    always_comb begin
        m_wide = {{2{m_q[XW-1]}}, m_q};
        pp     = '0;
        case (digit)
            POS1:    pp = m_wide;
            POS2:    pp = m_wide << 1;
            NEG1:    pp = -m_wide;
            NEG2:    pp = -(m_wide << 1);
            default: pp = '0;
        endcase
        sum       = acc_q + pp;
        acc_d     = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_d       = {sum[1:0], q_q[XW-1:2]};
        qm1_d     = q_q[1];
        // After the final step the low XW product bits sit in q, the rest in acc
        product_d = {acc_d[WIDTH-3:0], q_d};
        if (mode_q) begin
            overflow_d = !((&product_d[2*WIDTH-1:WIDTH-1]) || (~|product_d[2*WIDTH-1:WIDTH-1]));
        end else begin
            overflow_d = |product_d[2*WIDTH-1:WIDTH];
        end
    end

    // Control FSM and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clock) begin
        if (!reset_in) begin
            state_q    <= IDLE;
            count_q    <= '0;
            mode_q     <= 1'b0;
            m_q        <= '0;
            q_q        <= '0;
            qm1_q      <= 1'b0;
            acc_q      <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                        count_q <= '0;
                        mode_q  <= signed_in;
                        m_q     <= m_ext_in;
                        q_q     <= q_ext_in;
                        qm1_q   <= 1'b0;
                        acc_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                CALC: begin
                    acc_q   <= acc_d;
                    q_q     <= q_d;
                    qm1_q   <= qm1_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(ITER - 1)) begin
                        product_q  <= product_d;
                        overflow_q <= overflow_d;
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_out     = busy_q;
    assign done_out     = done_q;
    assign product_out  = product_q;
    assign overflow_out = overflow_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb/tb_seq_booth_multiplier.sv - scoreboard bench for seq_booth_multiplier
module tb_seq_booth_multiplier;

    localparam int W = 16;

    logic           clock = 1'b0;
    logic           reset_in = 1'b0;
    logic           start_in = 1'b0;
    logic           signed_in = 1'b0;
    logic [W-1:0]   multiplicand_in = '0;
    logic [W-1:0]   multiplier_in = '0;
    logic           busy_out;
    logic           done_out;
    logic [2*W-1:0] product_out;
    logic           overflow_out;

    typedef struct {
        logic [2*W-1:0] p;
        logic           ov;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    seq_booth_multiplier #(.WIDTH(W)) dut (
        .clock           (clock),
        .reset_in        (reset_in),
        .start_in        (start_in),
        .signed_in       (signed_in),
        .multiplicand_in (multiplicand_in),
        .multiplier_in   (multiplier_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .product_out     (product_out),
        .overflow_out    (overflow_out)
    );

    always #5 clock = ~clock;

    // Reference: exact integer product, then range test against a WIDTH-bit result
    function automatic exp_t model(input logic [W-1:0] m, input logic [W-1:0] q, input logic s);
        longint a;
        longint b;
        longint p;
        exp_t   e;
        a = s ? longint'($signed(m)) : longint'({48'b0, m});
        b = s ? longint'($signed(q)) : longint'({48'b0, q});
        p = a * b;
        e.p = p[31:0];
        if (s) e.ov = (p < -32768) || (p > 32767);
        else   e.ov = (p > 65535);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q, input logic s, input bit hold);
        int n;
        n = 0;
        while (busy_out && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (busy_out) check("issue_timeout", 64'd1, 64'd0);
        start_in        = 1'b1;
        signed_in       = s;
        multiplicand_in = m;
        multiplier_in   = q;
        sb.push_back(model(m, q, s));
        @(posedge clock);
        @(negedge clock);
        if (!hold) start_in = 1'b0;
        signed_in       = 1'($urandom);
        multiplicand_in = W'($urandom);
        multiplier_in   = W'($urandom);
    endtask

    task automatic wait_done(output int e);
        e = 0;
        while (!done_out && e < 60) begin
            @(negedge clock);
            e++;
        end
        if (!done_out) check("done_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_directed(input string name, input logic [W-1:0] m, input logic [W-1:0] q,
                                input logic s, input logic [2*W-1:0] ep, input logic eov);
        int e;
        issue(m, q, s, 1'b0);
        wait_done(e);
        check({name, "_product"}, 64'(product_out), 64'(ep));
        check({name, "_overflow"}, 64'(overflow_out), 64'(eov));
    endtask

    initial begin
        int   e;
        int   busyc;
        int   dones;
        exp_t ex;
        logic [W-1:0] rm;
        logic [W-1:0] rq;

        // Scoreboard monitor: every done pulse must match the oldest outstanding expectation
        fork
            forever begin
                @(negedge clock);
                if (done_out) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        ex = sb.pop_front();
                        check("sb_product", 64'(product_out), 64'(ex.p));
                        check("sb_overflow", 64'(overflow_out), 64'(ex.ov));
                    end
                end
            end
        join_none

        repeat (3) @(negedge clock);
        check("rst_busy", 64'(busy_out), 64'd0);
        check("rst_done", 64'(done_out), 64'd0);
        check("rst_product", 64'(product_out), 64'd0);
        check("rst_overflow", 64'(overflow_out), 64'd0);
        reset_in = 1'b1;
        @(negedge clock);

        // Latency and busy duration on unsigned 3*5
        issue(16'd3, 16'd5, 1'b0, 1'b0);
        e = 0;
        busyc = 0;
        while (!done_out && e < 60) begin
            if (busy_out) busyc++;
            @(negedge clock);
            e++;
        end
        check("latency", 64'(e), 64'd9);
        check("busy_cycles", 64'(busyc), 64'd9);
        check("u3x5_product", 64'(product_out), 64'h0000000F);
        check("u3x5_overflow", 64'(overflow_out), 64'd0);
        @(negedge clock);
        check("done_one_cycle", 64'(done_out), 64'd0);

        run_directed("sm3x5", 16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, 1'b0);
        run_directed("s8000sq", 16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b1);
        run_directed("uffffsq", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b1);
        run_directed("sffffsq", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1'b0);
        run_directed("u0xffff", 16'h0000, 16'hFFFF, 1'b0, 32'h00000000, 1'b0);
        run_directed("s1x8000", 16'h0001, 16'h8000, 1'b1, 32'hFFFF8000, 1'b0);

        // start_in held through CALC is ignored; dropped in the DONE cycle
        @(negedge clock);
        issue(16'h1234, 16'h0042, 1'b0, 1'b1);
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            if (done_out) begin
                dones++;
                start_in = 1'b0;
            end
            @(negedge clock);
        end
        start_in = 1'b0;
        check("held_start_single_done", 64'(dones), 64'd1);

        // Back-to-back issue in the DONE cycle
        issue(16'h00FF, 16'h0101, 1'b0, 1'b0);
        wait_done(e);
        issue(16'hFF00, 16'h0003, 1'b1, 1'b0);
        wait_done(e);
        check("b2b_spacing", 64'(e + 1), 64'd10);
        @(negedge clock);

        // Reset at count=4 discards the operation
        issue(16'h0F0F, 16'h0033, 1'b0, 1'b0);
        repeat (4) @(negedge clock);
        reset_in = 1'b0;
        void'(sb.pop_back());
        @(negedge clock);
        check("midrst_busy", 64'(busy_out), 64'd0);
        check("midrst_done", 64'(done_out), 64'd0);
        check("midrst_product", 64'(product_out), 64'd0);
        check("midrst_overflow", 64'(overflow_out), 64'd0);
        reset_in = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (done_out) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'd0);
        run_directed("u7x6", 16'h0007, 16'h0006, 1'b0, 32'h0000002A, 1'b0);

        // Randomized operations in both modes, gaps of 0..2 cycles after each done
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 7))
                0:       rm = 16'h8000;
                1:       rm = 16'hFFFF;
                2:       rm = 16'h7FFF;
                default: rm = W'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       rq = 16'h8000;
                1:       rq = 16'hFFFF;
                2:       rq = 16'h0000;
                default: rq = W'($urandom);
            endcase
            issue(rm, rq, 1'($urandom), 1'b0);
            wait_done(e);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (15) @(negedge clock);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_booth_multiplier.md
Name: seq_booth_multiplier

Overview:
- Parametrised successor to the radix-2 sequential multiplier; a multi-cycle radix-4 (modified Booth) multiplier that retires two multiplier bits per cycle.
- Adds a per-operation signed/unsigned mode, a busy/done handshake with back-to-back issue, and width-generic overflow detection.
- Sits as a standalone arithmetic unit behind any controller that pulses start_in and waits for done_out.

Parameters:
- WIDTH, 16, operand width in bits; must be even and >= 4 (elaboration-time assertion).
- ITER, (WIDTH/2)+1, Booth digit count / CALC cycles; derived constant, not overridden.

Ports:
- clock  in  1  rising-edge system clock
- reset_in  in  1  synchronous, active-low reset
- start_in  in  1  request; accepted only when busy_out=0
- signed_in  in  1  mode, sampled with start_in: 1=two's-complement, 0=unsigned
- multiplicand_in  in  WIDTH  operand M, sampled on accept
- multiplier_in  in  WIDTH  operand Q, sampled on accept
- busy_out  out  1  high while in CALC
- done_out  out  1  one-cycle pulse: product_out/overflow_out are valid
- product_out  out  2*WIDTH  registered result, held until next completion or reset
- overflow_out  out  1  result not representable in WIDTH bits (in selected mode)

Behaviour:
- Reset (reset_in=0 at a rising edge): state=IDLE; busy_out, done_out, overflow_out, product_out and all internal registers cleared to 0. Reset has priority over every other event, including mid-CALC; any in-flight operation is discarded with no done pulse.
- FSM states: IDLE, CALC, DONE.
- IDLE: start_in=1 -> capture operands and mode, count=0, go to CALC. Otherwise stay.
- CALC: busy_out=1. One Booth digit per edge. count increments. At count=ITER-1 the edge writes product_out and overflow_out and goes to DONE. start_in is ignored throughout CALC.
- DONE: done_out=1 for exactly this cycle; busy_out=0. start_in=1 -> accept a new operation (as from IDLE; back-to-back issue), else go to IDLE.
- Latency: accept at edge t0 -> done_out high in the cycle after edge t0+ITER (WIDTH=16: 9 CALC cycles, done 9 cycles after accept). Throughput is one result per ITER+1 cycles.
- Operand extension to WIDTH+2 bits: sign-extended if signed_in=1, zero-extended if 0. This applies to both M and Q.
- Booth recoding: Q extended with an implicit q[-1]=0. The bit triple {q[2i+1],q[2i],q[2i-1]} selects digit d in {0,+1,+2,-1,-2,-0}; the partial product d*M is added at weight 4^i.
- Accumulator: at least WIDTH+4 bits of headroom and arithmetic right shift by 2 per cycle, so no intermediate overflow can occur.
- product_out is the exact product, truncated to 2*WIDTH bits. The true product always fits, in both modes.
- overflow_out, signed mode: product_out[2*WIDTH-1:WIDTH-1] not all equal.
- overflow_out, unsigned mode: product_out[2*WIDTH-1:WIDTH] != 0.
- product_out/overflow_out change only on the final CALC edge or on reset; operand inputs may change freely after accept.

Decomposition:
- Package sbm_pkg: state enum (IDLE, CALC, DONE); Booth digit enum (ZERO, POS1, POS2, NEG1, NEG2); function iter_count(width).
- Sub-module booth_r4_encoder: combinational; 3-bit triple -> digit enum. Instantiated once inside seq_booth_multiplier.

Test Plan:
- Unsigned 3*5: WIDTH=16, signed_in=0 -> product_out=0x0000000F, overflow_out=0; done_out exactly 9 cycles after accept; busy_out high 9 cycles.
- Signed -3*5 (0xFFFD, 0x0005, signed_in=1) -> product_out=0xFFFFFFF1, overflow_out=0. Signed 0x8000*0x8000 -> 0x40000000, overflow_out=1.
- Unsigned extremes: 0xFFFF*0xFFFF -> 0xFFFE0001, overflow_out=1. Same operands with signed_in=1 -> 0x00000001, overflow_out=0.
- Handshake: start_in held high through CALC -> ignored, single done pulse. New start_in in DONE cycle -> accepted; second result 10 cycles after the first done.
- Reset mid-CALC: reset_in=0 at count=4 -> all outputs 0 next cycle, no done_out. Next start 0x0007*0x0006 -> 0x0000002A.
- Zero/identity sweep: 0*0xFFFF=0; 1*0x8000 in signed mode=0xFFFF8000 with overflow_out=0. Random 1000-op scoreboard in both modes matches a reference model.
